// File: rtl/divider_nbit_if.sv
// divider_nbit_if: start/done handshake and operand/result bus for divider_nbit
interface divider_nbit_if #(parameter int SIZE = 16);
  logic start;
  logic [SIZE-1:0] dividend;
  logic [SIZE-1:0] divisor;
  logic busy;
  logic done;
  logic [SIZE-1:0] quotient;
  logic [SIZE-1:0] remainder;
  logic div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/divider_nbit.sv
// divider_nbit: sequential restoring unsigned divider, one quotient bit per clock
module divider_nbit #(parameter int SIZE = 16) (
  input logic clk,
  input logic rst,
  divider_nbit_if.slave bus
);
  localparam int CW = $clog2(SIZE);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [SIZE-1:0] p, d, dvs, quo, rem, q_n, r_n;
  logic [CW-1:0] count;
  logic [SIZE:0] t, diff;
  logic ge, last, dbz;
  // T + ~divisor + 1 sets bit SIZE exactly when T >= divisor, since T < 2*divisor
  assign t = {p, d[SIZE-1]};
  assign diff = t + {1'b0, ~dvs} + {{SIZE{1'b0}}, 1'b1};
  assign ge = diff[SIZE];
  assign q_n = {d[SIZE-2:0], ge};
  assign r_n = ge ? diff[SIZE-1:0] : t[SIZE-1:0];
  assign last = count == CW'(SIZE - 1);
  assign bus.busy = state == CALC;
  assign bus.done = state == DONE;
  assign bus.quotient = quo;
  assign bus.remainder = rem;
  assign bus.div_by_zero = dbz;
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = bus.start ? (bus.divisor == '0 ? DONE : CALC) : IDLE;
    else if (state == CALC)
      state_n = last ? DONE : CALC;
    else
      state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
      d <= '0;
      dvs <= '0;
      count <= '0;
      quo <= '0;
      rem <= '0;
      dbz <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      d <= bus.dividend;
      dvs <= bus.divisor;
      p <= '0;
      count <= '0;
      if (bus.divisor == '0) begin
        quo <= '1;
        rem <= bus.dividend;
        dbz <= 1'b1;
      end
    end else if (state == CALC) begin
      p <= r_n;
      d <= q_n;
      count <= count + 1'b1;
      if (last) begin
        quo <= q_n;
        rem <= r_n;
        dbz <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_divider_nbit.sv
// tb_divider_nbit: directed self-checking bench for divider_nbit (SIZE=16)
module tb_divider_nbit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  divider_nbit_if #(.SIZE(16)) bus ();
  divider_nbit #(.SIZE(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // Launch a divide, optionally injecting a second start pulse (50/5) at cycle inj.
  // Returns the cycle done was first seen (0 = never) and the busy cycle count.
  task automatic run_div(input logic [15:0] a, input logic [15:0] b, input int inj,
                         output int lat, output int busy_cnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (i == inj) begin
        bus.start = 1'b1;
        bus.dividend = 16'd50;
        bus.divisor = 16'd5;
      end else if (i == inj + 1) bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.done) lat = i;
    end
  endtask
  task automatic test_reset;
    #3;
    vectors++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_basic;
    int lat, bc;
    run_div(16'd100, 16'd7, 0, lat, bc);
    vectors++;
    if (lat !== 17 || bc !== 16) begin
      miscompares++;
      $display("FAIL basic_timing: got latency=%0d busy=%0d, want 17 and 16", lat, bc);
    end
    vectors++;
    if (bus.quotient !== 16'd14 || bus.remainder !== 16'd2 || bus.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want 14 2 0",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask
  task automatic test_div_zero;
    int lat, bc;
    run_div(16'h1234, 16'h0000, 0, lat, bc);
    vectors++;
    if (lat !== 1 || bc !== 0) begin
      miscompares++;
      $display("FAIL dz_timing: got latency=%0d busy=%0d, want 1 and 0", lat, bc);
    end
    vectors++;
    if (bus.quotient !== 16'hFFFF || bus.remainder !== 16'h1234 || bus.div_by_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL dz_result: got q=%h r=%h dbz=%b, want ffff 1234 1",
               bus.quotient, bus.remainder, bus.div_by_zero);
    end
  endtask
  task automatic test_boundary;
    logic [15:0] tab [4][4];
    int lat, bc;
    tab[0] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000};
    tab[1] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000};
    tab[2] = '{16'h0005, 16'h0009, 16'h0000, 16'h0005};
    tab[3] = '{16'h0000, 16'h0003, 16'h0000, 16'h0000};
    for (int k = 0; k < 4; k++) begin
      run_div(tab[k][0], tab[k][1], 0, lat, bc);
      vectors++;
      if (lat !== 17 || bus.quotient !== tab[k][2] || bus.remainder !== tab[k][3] || bus.div_by_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL boundary_%0d: %h/%h got lat=%0d q=%h r=%h dbz=%b, want 17 %h %h 0",
                 k, tab[k][0], tab[k][1], lat, bus.quotient, bus.remainder, bus.div_by_zero,
                 tab[k][2], tab[k][3]);
      end
    end
  endtask
  task automatic test_ignored_start;
    int lat, bc, extra;
    run_div(16'd100, 16'd7, 5, lat, bc);
    vectors++;
    if (lat !== 17 || bus.quotient !== 16'd14 || bus.remainder !== 16'd2) begin
      miscompares++;
      $display("FAIL ignored_start: got lat=%0d q=%0d r=%0d, want 17 14 2", lat, bus.quotient, bus.remainder);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL ignored_start_queued: got %0d busy/done cycles afterwards, want 0", extra);
    end
  endtask
  task automatic test_mid_reset;
    int lat, bc, seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor = 16'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder} !== 35'd0) begin
      miscompares++;
      $display("FAIL mid_reset_async: got busy=%b done=%b dbz=%b q=%h r=%h, want all 0",
               bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_abort: got %0d busy/done cycles after reset, want 0", seen);
    end
    run_div(16'd9, 16'd3, 0, lat, bc);
    vectors++;
    if (lat !== 17 || bus.quotient !== 16'd3 || bus.remainder !== 16'd0) begin
      miscompares++;
      $display("FAIL after_reset: got lat=%0d q=%0d r=%0d, want 17 3 0", lat, bus.quotient, bus.remainder);
    end
  endtask
  task automatic test_back_to_back;
    int lat, bc;
    run_div(16'd1000, 16'd10, 0, lat, bc);
    vectors++;
    if (lat !== 17 || bc !== 16 || bus.quotient !== 16'd100 || bus.remainder !== 16'd0) begin
      miscompares++;
      $display("FAIL b2b_first: got lat=%0d busy=%0d q=%0d r=%0d, want 17 16 100 0",
               lat, bc, bus.quotient, bus.remainder);
    end
    run_div(16'd7, 16'd2, 0, lat, bc);
    vectors++;
    if (lat !== 17 || bc !== 16 || bus.quotient !== 16'd3 || bus.remainder !== 16'd1) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d busy=%0d q=%0d r=%0d, want 17 16 3 1",
               lat, bc, bus.quotient, bus.remainder);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.quotient !== 16'd3 || bus.remainder !== 16'd1) begin
      miscompares++;
      $display("FAIL b2b_hold: got done=%b q=%0d r=%0d, want 0 3 1", bus.done, bus.quotient, bus.remainder);
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    test_reset;
    test_basic;
    test_div_zero;
    test_boundary;
    test_ignored_start;
    test_mid_reset;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
